// File: rtl/cam_pkg.sv
// Shared types and constants for the camera frame player.
package cam_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_RUN   = 2'd2
  } cam_state_e;

  localparam int FRAME_CNT_W = 16;
endpackage

// File: rtl/cam_frame_player_if.sv
// Frame-buffer write port plus playback stream bundle for cam_frame_player.
interface cam_frame_player_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 14,
  parameter int CH     = 1
) ();
  import cam_pkg::*;

  logic                   wr_en;
  logic [ADDR_W-1:0]      wr_addr;
  logic [CH*DATA_W-1:0]   wr_data;
  logic [ADDR_W-1:0]      frame_len;
  logic                   enable;
  logic                   rdy_i;
  logic                   out_valid;
  logic [CH-1:0]          out_bit;
  logic [CH*DATA_W-1:0]   out_word;
  logic                   sof;
  logic                   eof;
  logic [FRAME_CNT_W-1:0] frame_cnt;
  logic                   len_err;

  modport master (
    output wr_en, wr_addr, wr_data, frame_len, enable, rdy_i,
    input  out_valid, out_bit, out_word, sof, eof, frame_cnt, len_err
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, frame_len, enable, rdy_i,
    output out_valid, out_bit, out_word, sof, eof, frame_cnt, len_err
  );
endinterface

// File: rtl/cam_frame_ram.sv
// Simple dual-port frame buffer, one-cycle registered read, read-before-write.
module cam_frame_ram #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 14,
  parameter int DEPTH  = 15440
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [WIDTH-1:0] rd_data_reg;

  // No reset here so the array maps onto block RAM and survives rst.
  always_ff @(posedge clk) begin
    if (wr_en && ({1'b0, wr_addr} < DEPTH_L)) begin
      mem_reg[wr_addr] <= wr_data;
    end
    rd_data_reg <= mem_reg[rd_addr];
  end

  assign rd_data = rd_data_reg;
endmodule

// File: rtl/cam_frame_player.sv
// Replays a stored frame as a word or bit-serial stream with ready backpressure.
module cam_frame_player
  import cam_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 14,
  parameter int DEPTH  = 15440,
  parameter int CH     = 1,
  parameter int SERIAL = 1
) (
  input  logic               clk,
  input  logic               rst,
  cam_frame_player_if.slave  bus
);
  localparam int              BIT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [ADDR_W:0] DEPTH_L  = (ADDR_W+1)'(DEPTH);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

  cam_state_e             state_reg, state_next;
  logic [ADDR_W-1:0]      addr_reg, addr_next;
  logic [ADDR_W-1:0]      len_reg, len_next;
  logic [BIT_W-1:0]       bit_reg, bit_next;
  logic [FRAME_CNT_W-1:0] frame_cnt_reg, frame_cnt_next;
  logic                   len_err_reg, len_err_next;
  logic                   load_reg, load_next;
  logic [CH*DATA_W-1:0]   word_reg, rd_data, cur_word;
  logic [CH-1:0]          out_bit_w;
  logic                   xfer, last_bit, last_word, word_adv, len_bad;

  // Read address is the next-cycle word address, so the RAM output lines up
  // with addr_reg and a new word is ready the cycle after an advance.
  cam_frame_ram #(.WIDTH(CH*DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_ram (
    .clk     (clk),
    .wr_en   (bus.wr_en),
    .wr_addr (bus.wr_addr),
    .wr_data (bus.wr_data),
    .rd_addr (addr_next),
    .rd_data (rd_data)
  );

  assign bus.out_valid = (state_reg == ST_RUN);
  assign xfer          = bus.out_valid & bus.rdy_i;
  assign last_bit      = (SERIAL == 0) || (bit_reg == LAST_BIT);
  assign last_word     = (addr_reg == len_reg - ADDR_W'(1));
  assign word_adv      = xfer & last_bit;
  assign len_bad       = (len_reg == '0) || ({1'b0, len_reg} > DEPTH_L);

  // Fresh RAM data is shown only right after a load; otherwise hold the copy
  // so stalls and concurrent writes cannot disturb the visible word.
  assign cur_word      = load_reg ? rd_data : word_reg;
  assign bus.out_word  = bus.out_valid ? cur_word : '0;
  assign bus.sof       = xfer & (addr_reg == '0) & (bit_reg == '0);
  assign bus.eof       = word_adv & last_word;
  assign bus.frame_cnt = frame_cnt_reg;
  assign bus.len_err   = len_err_reg;
  assign bus.out_bit   = out_bit_w;

  for (genvar gi = 0; gi < CH; gi++) begin : g_lane
    if (SERIAL != 0) begin : g_ser
      logic [DATA_W-1:0] lane_word;
      assign lane_word     = cur_word[gi*DATA_W +: DATA_W];
      assign out_bit_w[gi] = bus.out_valid & lane_word[bit_reg];
    end else begin : g_par
      assign out_bit_w[gi] = 1'b0;
    end
  end

  always_comb begin
    state_next     = state_reg;
    addr_next      = addr_reg;
    bit_next       = bit_reg;
    len_next       = len_reg;
    frame_cnt_next = frame_cnt_reg;
    len_err_next   = len_err_reg;
    load_next      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        addr_next = '0;
        bit_next  = '0;
        if (bus.enable) begin
          state_next = ST_FETCH;
          len_next   = bus.frame_len;
        end
      end
      ST_FETCH: begin
        if (!bus.enable) begin
          state_next = ST_IDLE;
        end else if (len_bad) begin
          state_next   = ST_IDLE;
          len_err_next = 1'b1;
        end else begin
          state_next = ST_RUN;
          load_next  = 1'b1;
        end
      end
      ST_RUN: begin
        if (word_adv) begin
          bit_next  = '0;
          load_next = 1'b1;
          if (last_word) begin
            addr_next      = '0;
            frame_cnt_next = frame_cnt_reg + FRAME_CNT_W'(1);
          end else begin
            addr_next = addr_reg + ADDR_W'(1);
          end
        end else if (xfer) begin
          bit_next = bit_reg + BIT_W'(1);
        end
        if (!bus.enable) begin
          state_next = ST_IDLE;
          addr_next  = '0;
          bit_next   = '0;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      addr_reg      <= '0;
      len_reg       <= '0;
      bit_reg       <= '0;
      frame_cnt_reg <= '0;
      len_err_reg   <= 1'b0;
      load_reg      <= 1'b0;
      word_reg      <= '0;
    end else begin
      state_reg     <= state_next;
      addr_reg      <= addr_next;
      len_reg       <= len_next;
      bit_reg       <= bit_next;
      frame_cnt_reg <= frame_cnt_next;
      len_err_reg   <= len_err_next;
      load_reg      <= load_next;
      word_reg      <= cur_word;
    end
  end
endmodule
